scan_mux: RTL and testbench

Upstream time-multiplexing stage for the seven-segment path. It cycles through NUM_DIGITS 4-bit digit values and presents one digit per refresh slot on DATA_OUT, which feeds the segment decoder's DATA input. It also drives the matching one-hot SCAN_OUT position enables. Digit values are double-buffered per frame so a digit never tears mid-scan; optional leading-zero blanking and per-digit decimal points are included.

---
 rtl/scan_mux_if.sv | 13 +
 rtl/scan_mux.sv | 63 ++++++
 tb/tb_scan_mux.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/scan_mux_if.sv
// scan_mux_if: digit/DP inputs and scanned display outputs of the seven-segment multiplexer
interface scan_mux_if #(parameter int NUM_DIGITS = 4);
  logic [4*NUM_DIGITS-1:0] DIGITS_IN;
  logic [NUM_DIGITS-1:0] DP_IN;
  logic BLANK_EN;
  logic [3:0] DATA_OUT;
  logic DP_OUT;
  logic [NUM_DIGITS-1:0] SCAN_OUT;
  logic BLANK_OUT;
  logic FRAME_OUT;
  modport master(output DIGITS_IN, DP_IN, BLANK_EN, input DATA_OUT, DP_OUT, SCAN_OUT, BLANK_OUT, FRAME_OUT);
  modport slave(input DIGITS_IN, DP_IN, BLANK_EN, output DATA_OUT, DP_OUT, SCAN_OUT, BLANK_OUT, FRAME_OUT);
endinterface

// File: rtl/scan_mux.sv
// scan_mux: frame-buffered digit scanner with leading-zero blanking and decimal points
module scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV = 50000,
  parameter int DIV_W = 16
) (
  input logic CLK,
  input logic RST,
  scan_mux_if.slave bus
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  logic [DIV_W-1:0] cnt;
  logic [IW-1:0] idx, nidx;
  logic [4*NUM_DIGITS-1:0] sd, ed;
  logic [NUM_DIGITS-1:0] sdp, edp, nz, clr, blank;
  logic [3:0] nd;
  logic tick, frame;
  assign tick = cnt == DIV_W'(DIV - 1);
  assign frame = tick && idx == LAST;
  assign nidx = idx == LAST ? '0 : idx + 1'b1;
  // the frame edge shows slot 0 from the values being latched, not the stale shadow
  assign ed = frame ? bus.DIGITS_IN : sd;
  assign edp = frame ? bus.DP_IN : sdp;
  always_comb begin
    nd = '0;
    nz = '0;
    clr = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nz[i] = |ed[4*i+:4] | edp[i];
      if (IW'(i) == nidx) nd = ed[4*i+:4];
    end
    for (int i = 0; i < NUM_DIGITS; i++) clr[i] = ~|(nz >> (i + 1));
    blank = {NUM_DIGITS{bus.BLANK_EN}} & clr & ~nz & ~NUM_DIGITS'(1);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
      idx <= '0;
      sd <= '0;
      sdp <= '0;
      bus.DATA_OUT <= '0;
      bus.DP_OUT <= 1'b0;
      bus.SCAN_OUT <= NUM_DIGITS'(1);
      bus.BLANK_OUT <= 1'b0;
      bus.FRAME_OUT <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      bus.FRAME_OUT <= frame;
      if (frame) begin
        sd <= bus.DIGITS_IN;
        sdp <= bus.DP_IN;
      end
      if (tick) begin
        idx <= nidx;
        bus.DATA_OUT <= nd;
        bus.DP_OUT <= edp[nidx] & ~blank[nidx];
        bus.SCAN_OUT <= blank[nidx] ? '0 : NUM_DIGITS'(1) << nidx;
        bus.BLANK_OUT <= blank[nidx];
      end
    end
  end
endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: directed scenario checks of scan_mux with NUM_DIGITS=4, DIV=4
module tb_scan_mux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  scan_mux_if #(.NUM_DIGITS(4)) bus ();
  scan_mux #(.NUM_DIGITS(4), .DIV(4), .DIV_W(4)) dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [10:0] obs;
  assign obs = {bus.SCAN_OUT, bus.DATA_OUT, bus.DP_OUT, bus.BLANK_OUT, bus.FRAME_OUT};

  function automatic logic [10:0] pk(input logic [3:0] scan, input logic [3:0] data, input logic dp, input logic bl, input logic fr);
    return {scan, data, dp, bl, fr};
  endfunction

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.FRAME_OUT) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic skip(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    int first;
    bus.DIGITS_IN = '0;
    bus.DP_IN = '0;
    bus.BLANK_EN = 1'b0;
    rst = 1'b1;
    skip(2);
    rst = 1'b0;
    checks++;
    if (obs !== pk(4'b0001, 4'h0, 1'b0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset_state got %h want %h", obs, pk(4'b0001, 4'h0, 1'b0, 1'b0, 1'b0));
    end
    first = 0;
    for (int k = 1; k <= 20 && first == 0; k++) begin
      @(negedge clk);
      if (k == 4) begin
        checks++;
        if (bus.SCAN_OUT !== 4'b0010) begin
          errors++;
          $display("FAIL reset_slot1 got %b want 0010", bus.SCAN_OUT);
        end
      end
      if (bus.FRAME_OUT) first = k;
    end
    checks++;
    if (first != 16) begin
      errors++;
      $display("FAIL reset_first_frame got %0d want 16", first);
    end
  endtask

  task automatic test_scan;
    bit ok;
    logic [3:0] d [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    logic [10:0] e;
    int s;
    bus.DIGITS_IN = 16'h1234;
    bus.BLANK_EN = 1'b0;
    wait_frame(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL scan_frame_timeout got 0 want 1");
    end
    for (int m = 0; m < 32; m++) begin
      s = (m / 4) % 4;
      e = pk(4'(1 << s), d[s], 1'b0, 1'b0, m % 16 == 0);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL scan_m%0d got %h want %h", m, obs, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_blank;
    bit ok;
    logic [10:0] e1 [4];
    logic [10:0] e2 [4];
    e1 = '{pk(4'b0001, 4'h0, 0, 0, 1), pk(4'b0010, 4'h5, 0, 0, 0), pk(4'b0000, 4'h0, 0, 1, 0), pk(4'b0000, 4'h0, 0, 1, 0)};
    e2 = '{pk(4'b0001, 4'h0, 0, 0, 1), pk(4'b0000, 4'h0, 0, 1, 0), pk(4'b0000, 4'h0, 0, 1, 0), pk(4'b0000, 4'h0, 0, 1, 0)};
    bus.DIGITS_IN = 16'h0050;
    bus.BLANK_EN = 1'b1;
    wait_frame(ok);
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (obs !== e1[s]) begin
        errors++;
        $display("FAIL blank50_slot%0d got %h want %h", s, obs, e1[s]);
      end
      skip(4);
    end
    bus.DIGITS_IN = 16'h0000;
    wait_frame(ok);
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (obs !== e2[s]) begin
        errors++;
        $display("FAIL blank0_slot%0d got %h want %h", s, obs, e2[s]);
      end
      skip(4);
    end
  endtask

  task automatic test_dp;
    bit ok;
    logic [10:0] e [4];
    e = '{pk(4'b0001, 4'h0, 0, 0, 1), pk(4'b0010, 4'h0, 0, 0, 0), pk(4'b0100, 4'h0, 1, 0, 0), pk(4'b0000, 4'h0, 0, 1, 0)};
    bus.DIGITS_IN = 16'h0000;
    bus.DP_IN = 4'b0100;
    bus.BLANK_EN = 1'b1;
    wait_frame(ok);
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (obs !== e[s]) begin
        errors++;
        $display("FAIL dp_slot%0d got %h want %h", s, obs, e[s]);
      end
      skip(4);
    end
    bus.DP_IN = 4'b0000;
    bus.BLANK_EN = 1'b0;
  endtask

  task automatic test_tear;
    bit ok;
    bus.DIGITS_IN = 16'h1111;
    wait_frame(ok);
    skip(8);
    bus.DIGITS_IN = 16'h9999;
    checks++;
    if (obs !== pk(4'b0100, 4'h1, 0, 0, 0)) begin
      errors++;
      $display("FAIL tear_slot2 got %h want %h", obs, pk(4'b0100, 4'h1, 0, 0, 0));
    end
    skip(4);
    checks++;
    if (obs !== pk(4'b1000, 4'h1, 0, 0, 0)) begin
      errors++;
      $display("FAIL tear_slot3 got %h want %h", obs, pk(4'b1000, 4'h1, 0, 0, 0));
    end
    skip(4);
    checks++;
    if (obs !== pk(4'b0001, 4'h9, 0, 0, 1)) begin
      errors++;
      $display("FAIL tear_bypass got %h want %h", obs, pk(4'b0001, 4'h9, 0, 0, 1));
    end
  endtask

  task automatic test_midreset;
    int first;
    skip(9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (obs !== pk(4'b0001, 4'h0, 0, 0, 0)) begin
      errors++;
      $display("FAIL midreset_state got %h want %h", obs, pk(4'b0001, 4'h0, 0, 0, 0));
    end
    first = 0;
    for (int k = 1; k <= 24 && first == 0; k++) begin
      @(negedge clk);
      if (k == 3 || k == 4) begin
        checks++;
        if (bus.SCAN_OUT !== (k == 4 ? 4'b0010 : 4'b0001)) begin
          errors++;
          $display("FAIL midreset_prescale_k%0d got %b want %b", k, bus.SCAN_OUT, k == 4 ? 4'b0010 : 4'b0001);
        end
      end
      if (bus.FRAME_OUT) first = k;
    end
    checks++;
    if (first != 16) begin
      errors++;
      $display("FAIL midreset_frame got %0d want 16", first);
    end
    checks++;
    if (bus.DATA_OUT !== 4'h9) begin
      errors++;
      $display("FAIL midreset_reload got %h want 9", bus.DATA_OUT);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_scan;
    test_blank;
    test_dp;
    test_tear;
    test_midreset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
